pipelined_carry_select_subtractor: RTL and testbench

- Computes the N-bit unsigned/two's-complement difference a - b as a + ~b + 1.
- Splits the operands into N/B blocks of B bits. Each pipeline stage resolves one block with a carry-select pair and selects using the carry registered by the previous stage.
- Valid/ready handshake on input and output, so it plugs into the streaming datapath next to the existing adders.
- Provides borrow and signed-overflow flags for compare and ALU use.

---
 rtl/pipelined_carry_select_subtractor_pkg.sv | 12 +
 rtl/pipelined_carry_select_subtractor_csel.sv | 39 +++
 rtl/pipelined_carry_select_subtractor.sv | 157 +++++++++++++++
 tb/tb_pipelined_carry_select_subtractor.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_carry_select_subtractor_pkg.sv
// Shared defaults and helpers for the pipelined carry-select subtractor.
package pipelined_carry_select_subtractor_pkg;

  localparam int DEFAULT_N = 16;
  localparam int DEFAULT_B = 4;

  // One pipeline stage per B-bit block.
  function automatic int calc_stages(input int n, input int b);
    return (b > 0) ? (n / b) : 1;
  endfunction

endpackage

// File: rtl/pipelined_carry_select_subtractor_csel.sv
// Combinational carry-select block: computes a + ~b + cin for one B-bit slice.
// Both carry-in cases are evaluated up front so the late-arriving cin only
// drives a 2:1 mux.
module csel_sub_block #(
  parameter int B = 4
) (
  input  logic [B-1:0] a,
  input  logic [B-1:0] b,
  input  logic         cin,
  output logic [B-1:0] sum,
  output logic         cout
);

  logic [B-1:0] nb;

  assign nb = ~b;

  // Two ripple-carry adders: instance 0 assumes carry-in 0, instance 1 assumes 1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rca
    logic [B-1:0] s;
    logic         c;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
      logic carry;
      carry = (gi == 1);
      s     = '0;
      for (int i = 0; i < B; i++) begin
        s[i]  = a[i] ^ nb[i] ^ carry;
        carry = (a[i] & nb[i]) | (carry & (a[i] ^ nb[i]));
      end
      c = carry;
    end
  end

  assign sum  = cin ? g_rca[1].s : g_rca[0].s;
  assign cout = cin ? g_rca[1].c : g_rca[0].c;

endmodule

// File: rtl/pipelined_carry_select_subtractor.sv
// Pipelined N-bit subtractor (a - b = a + ~b + 1), one B-bit carry-select
// block per stage, with a valid/ready stream interface plus borrow and
// signed-overflow flags. Operand blocks are skewed in and result blocks
// deskewed out so every operation leaves the pipe as one aligned word.
module pipelined_carry_select_subtractor
  import pipelined_carry_select_subtractor_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int B = DEFAULT_B
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int STAGES = calc_stages(N, B);

  if ((N % B) != 0) begin : g_bad_width
    $error("pipelined_carry_select_subtractor: N must be an integer multiple of B");
  end

  logic              en;
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] a_msb_reg;
  logic [STAGES-1:0] b_msb_reg;
  logic [STAGES-1:0] carry_reg;
  logic [B-1:0]      sum_reg [STAGES];
  logic [B-1:0]      blk_a   [STAGES];
  logic [B-1:0]      blk_b   [STAGES];
  logic              blk_cin [STAGES];
  logic [B-1:0]      sel_sum [STAGES];
  logic [STAGES-1:0] sel_cout;
  logic [B-1:0]      out_blk [STAGES];
  logic [N-1:0]      diff_w;

  // A single global enable: the whole pipe advances only when the output
  // slot is empty or being drained this cycle.
  assign en        = ~valid_reg[STAGES-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = valid_reg[STAGES-1];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      // Block 0 is resolved in the accept cycle; its carry-in is the +1.
      assign blk_a[gi]   = a[gi*B +: B];
      assign blk_b[gi]   = b[gi*B +: B];
      assign blk_cin[gi] = 1'b1;
    end else begin : g_skew
      logic [B-1:0] a_dly [gi];
      logic [B-1:0] b_dly [gi];

      // Delay this block's operands by gi cycles so they meet the carry
      // coming out of stage gi-1.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < gi; j++) begin
            a_dly[j] <= '0;
            b_dly[j] <= '0;
          end
        end else if (en) begin
          a_dly[0] <= a[gi*B +: B];
          b_dly[0] <= b[gi*B +: B];
          for (int j = 1; j < gi; j++) begin
            a_dly[j] <= a_dly[j-1];
            b_dly[j] <= b_dly[j-1];
          end
        end
      end

      assign blk_a[gi]   = a_dly[gi-1];
      assign blk_b[gi]   = b_dly[gi-1];
      assign blk_cin[gi] = carry_reg[gi-1];
    end

    csel_sub_block #(.B(B)) u_blk (
      .a    (blk_a[gi]),
      .b    (blk_b[gi]),
      .cin  (blk_cin[gi]),
      .sum  (sel_sum[gi]),
      .cout (sel_cout[gi])
    );

    localparam int DESKEW = STAGES - 1 - gi;

    if (DESKEW == 0) begin : g_last
      assign out_blk[gi] = sum_reg[gi];
    end else begin : g_deskew
      logic [B-1:0] res_dly [DESKEW];

      // Hold early result blocks back until the top block catches up.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < DESKEW; j++) begin
            res_dly[j] <= '0;
          end
        end else if (en) begin
          res_dly[0] <= sum_reg[gi];
          for (int j = 1; j < DESKEW; j++) begin
            res_dly[j] <= res_dly[j-1];
          end
        end
      end

      assign out_blk[gi] = res_dly[DESKEW-1];
    end
  end

  // Per-stage state: valid bits, operand sign bits riding along for the
  // overflow flag, and the selected sum/carry of each block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      a_msb_reg <= '0;
      b_msb_reg <= '0;
      carry_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_reg[k] <= '0;
      end
    end else if (en) begin
      valid_reg[0] <= in_valid;
      a_msb_reg[0] <= a[N-1];
      b_msb_reg[0] <= b[N-1];
      for (int k = 1; k < STAGES; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        a_msb_reg[k] <= a_msb_reg[k-1];
        b_msb_reg[k] <= b_msb_reg[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        sum_reg[k] <= sel_sum[k];
      end
      carry_reg <= sel_cout;
    end
  end

  // Reassemble the aligned result blocks into one word.
  always_comb begin
    diff_w = '0;
    for (int k = 0; k < STAGES; k++) begin
      diff_w[k*B +: B] = out_blk[k];
    end
  end

  assign diff = diff_w;
  // Flags are qualified by out_valid so they read 0 out of reset and on bubbles.
  assign bout = out_valid & ~carry_reg[STAGES-1];
  assign ovf  = out_valid & (a_msb_reg[STAGES-1] ^ b_msb_reg[STAGES-1])
                          & (diff_w[N-1] ^ a_msb_reg[STAGES-1]);

endmodule

// File: tb/tb_pipelined_carry_select_subtractor.sv
// Bench for pipelined_carry_select_subtractor: three configurations
// (16/4, 16/16, 32/8) each get directed cases followed by a random stream,
// all checked against a reference subtraction through a scoreboard.
module tb_pipelined_carry_select_subtractor;

  typedef struct packed {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  localparam int NOPS = 3400;

  logic clk = 1'b0;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   done_count   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide subtraction, borrow from unsigned compare,
  // overflow from the operand/result sign rule.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int n);
    logic [31:0] mask;
    logic [32:0] wide;
    exp_t        e;
    mask   = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    x      = x & mask;
    y      = y & mask;
    wide   = {1'b0, x} - {1'b0, y};
    e.diff = wide[31:0] & mask;
    e.bout = (x < y);
    e.ovf  = (x[n-1] != y[n-1]) && (e.diff[n-1] != x[n-1]);
    return e;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int NW = (gi == 2) ? 32 : 16;
    localparam int BW = (gi == 0) ? 4 : ((gi == 1) ? 16 : 8);
    localparam int ST = NW / BW;

    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] a;
    logic [NW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] diff;
    logic          bout;
    logic          ovf;
    exp_t          sb [$];
    exp_t          e;

    pipelined_carry_select_subtractor #(.N(NW), .B(BW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
    );

    function automatic string tg(input string s);
      return $sformatf("cfg%0d_%s", gi, s);
    endfunction

    function automatic logic [NW-1:0] pick();
      logic [NW-1:0] msb;
      msb         = '0;
      msb[NW-1]   = 1'b1;
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        2:       return msb;
        3:       return ~msb;
        4:       return NW'(1);
        default: return NW'({$urandom(), $urandom()});
      endcase
    endfunction

    // Scoreboard: pop/compare on each output handshake, push on each accept.
    always @(negedge clk) begin
      if (!rst) begin
        if (out_valid && out_ready) begin
          check(tg("result_expected"), 64'(sb.size() > 0), 64'(1));
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check(tg("diff"), 64'(diff), 64'(e.diff));
            check(tg("bout"), 64'(bout), 64'(e.bout));
            check(tg("ovf"),  64'(ovf),  64'(e.ovf));
          end
        end
        if (in_valid && in_ready) begin
          sb.push_back(model(32'(a), 32'(b), NW));
        end
      end
    end

    // Present one op and hold it until accepted; returns just after the accept edge.
    task automatic drive_op(input logic [NW-1:0] x, input logic [NW-1:0] y);
      int t;
      t        = 0;
      in_valid = 1'b1;
      a        = x;
      b        = y;
      @(negedge clk);
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) check(tg("accept_timeout"), 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int t;
      t         = 0;
      out_ready = 1'b1;
      while ((sb.size() != 0 || out_valid) && t < 200) begin
        @(posedge clk);
        #1;
        t++;
      end
      check(tg("drained"), 64'(sb.size() == 0 && !out_valid), 64'(1));
    endtask

    task automatic stall_outputs();
      int            t;
      logic [NW-1:0] hd;
      logic          hb;
      logic          ho;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      check(tg("stall_first_out"), 64'(out_valid), 64'(1));
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      hd = diff;
      hb = bout;
      ho = ovf;
      repeat (3) begin
        @(negedge clk);
        check(tg("stall_in_ready"),  64'(in_ready),  64'(0));
        check(tg("stall_out_valid"), 64'(out_valid), 64'(1));
        check(tg("stall_diff_held"), 64'(diff),      64'(hd));
        check(tg("stall_bout_held"), 64'(bout),      64'(hb));
        check(tg("stall_ovf_held"),  64'(ovf),       64'(ho));
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
    endtask

    initial begin
      int         k;
      int         t;
      int         accepted;
      logic       acc;
      logic [7:0] pat;
      logic       ov [12];

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check(tg("rst_out_valid"), 64'(out_valid), 64'(0));
      check(tg("rst_in_ready"),  64'(in_ready),  64'(1));
      check(tg("rst_diff"),      64'(diff),      64'(0));
      check(tg("rst_bout"),      64'(bout),      64'(0));
      check(tg("rst_ovf"),       64'(ovf),       64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // First op also measures latency in accept-to-output edges.
      drive_op(NW'(16'h1234), NW'(16'h0234));
      k = 1;
      @(negedge clk);
      while (!out_valid && k < 20) begin
        @(posedge clk);
        #1;
        k++;
        @(negedge clk);
      end
      check(tg("latency"), 64'(k), 64'(ST));
      @(posedge clk);
      #1;
      wait_idle();
      drive_op(NW'(16'h0000), NW'(16'h0001));
      wait_idle();
      drive_op(NW'(16'h8000), NW'(16'h0001));
      wait_idle();

      // Back-to-back stream with a 3-cycle output stall.
      fork
        begin
          drive_op(NW'(5), NW'(3));
          drive_op(NW'(3), NW'(5));
          drive_op(NW'(16'h7FFF), NW'(16'hFFFF));
          drive_op(NW'(16'hABCD), NW'(16'hABCD));
        end
        stall_outputs();
      join
      wait_idle();

      // Bubbles: out_valid must replay the in_valid pattern ST edges later.
      pat = 8'b0100_1101;
      for (int c = 0; c < 12; c++) begin
        in_valid = (c < 8) ? pat[c] : 1'b0;
        a        = pick();
        b        = pick();
        @(negedge clk);
        ov[c] = out_valid;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
        check(tg($sformatf("bubble_%0d", c)), 64'(ov[c+ST]), 64'(pat[c]));
      end
      wait_idle();

      // Reset with ops in flight and one parked at the output.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = NW'(16'h0042);
      b         = NW'(16'h0011);
      @(posedge clk);
      #1;
      a = NW'(16'h0100);
      b = NW'(16'h0200);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check(tg("pre_rst_out_valid"), 64'(out_valid), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      check(tg("async_rst_out_valid"), 64'(out_valid), 64'(0));
      check(tg("async_rst_diff"),      64'(diff),      64'(0));
      check(tg("async_rst_bout"),      64'(bout),      64'(0));
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #2;
      rst       = 1'b0;
      out_ready = 1'b1;
      repeat (10) begin
        @(negedge clk);
        check(tg("post_rst_quiet"), 64'(out_valid), 64'(0));
      end
      @(posedge clk);
      #1;

      // Random stream with random source gaps and sink back-pressure.
      accepted = 0;
      acc      = 1'b0;
      t        = 0;
      while (accepted < NOPS && t < 40000) begin
        if (!in_valid || acc) begin
          in_valid = ($urandom_range(0, 9) < 7);
          a        = pick();
          b        = pick();
        end
        out_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) accepted++;
        @(posedge clk);
        #1;
        t++;
      end
      in_valid = 1'b0;
      check(tg("random_ops_accepted"), 64'(accepted), 64'(NOPS));
      wait_idle();
      done_count++;
    end
  end

  initial begin
    for (int t = 0; t < 90000 && done_count < 3; t++) begin
      @(posedge clk);
    end
    check("all_cfgs_done", 64'(done_count), 64'(3));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
